// File: rtl/regfile_pkg.sv
// Shared register-file constants for the write-select and scoreboard logic.
// Register 0 is the architecturally hardwired zero register.
package regfile_pkg;
  localparam int REG_ADDR_W   = 5;
  localparam int REG_NUM      = 32;
  localparam int ZERO_REG_IDX = 0;
endpackage

// File: rtl/onehot_decoder.sv
// Combinational address to one-hot decoder; all-zero output when en is low.
// Latency: none. Backpressure: none, pure function of inputs.
module onehot_decoder #(
  parameter int ADDR_W = 5,
  localparam int NREGS = 2**ADDR_W
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              en_i,
  output logic [NREGS-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/regfile_wr_scoreboard.sv
// Pending-write scoreboard with registered one-hot write enable and RAW hazard flags.
// Latency: write enable one cycle after write-back. Backpressure: issue_ready_o low on a busy destination.
module regfile_wr_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int ZERO_REG = 1,
  localparam int NREGS   = 2**ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  output logic              issue_ready_o,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  output logic [NREGS-1:0]  wr_en_o,
  output logic [NREGS-1:0]  pending_o,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic              hazard_a_o,
  output logic              hazard_b_o,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_IDX);
  localparam logic              ZERO_EN   = (ZERO_REG != 0);

  logic [NREGS-1:0] pending_q, pending_d;
  logic [NREGS-1:0] wr_en_q, wr_en_d;
  logic             err_q, err_d;

  logic             issue_zero, wb_zero, issue_fire, wb_eff;
  logic [NREGS-1:0] set_mask, clr_mask;

  assign issue_zero    = ZERO_EN && (issue_addr_i == ZERO_ADDR);
  assign wb_zero       = ZERO_EN && (wb_addr_i == ZERO_ADDR);
  assign issue_ready_o = issue_zero || !pending_q[issue_addr_i];
  assign issue_fire    = issue_valid_i && issue_ready_o && !issue_zero;
  assign wb_eff        = wb_valid_i && !wb_zero;

  onehot_decoder #(.ADDR_W(ADDR_W)) u_issue_dec (
    .addr_i   (issue_addr_i),
    .en_i     (issue_fire),
    .onehot_o (set_mask)
  );

  onehot_decoder #(.ADDR_W(ADDR_W)) u_wb_dec (
    .addr_i   (wb_addr_i),
    .en_i     (wb_eff),
    .onehot_o (clr_mask)
  );

  // Set is applied after clear so an issue to a non-pending register wins
  // over a same-cycle write-back to that register.
  always_comb begin
    pending_d = (pending_q & ~clr_mask) | set_mask;
    wr_en_d   = clr_mask;
    err_d     = err_q | (wb_eff && !pending_q[wb_addr_i]);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
      wr_en_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      wr_en_q   <= wr_en_d;
      err_q     <= err_d;
    end
  end

  assign pending_o  = pending_q;
  assign wr_en_o    = wr_en_q;
  assign err_o      = err_q;
  assign hazard_a_o = !(ZERO_EN && (rd_addr_a_i == ZERO_ADDR)) && pending_q[rd_addr_a_i];
  assign hazard_b_o = !(ZERO_EN && (rd_addr_b_i == ZERO_ADDR)) && pending_q[rd_addr_b_i];

endmodule
